// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one combinational ALU
// between two valid/ready requesters. Operands are registered into the ALU
// on accept, the result/flags are captured one cycle later, and the
// response is held until the consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_src1,
    input  logic [WIDTH-1:0] req0_src2,
    input  logic [3:0]       req0_op,
    input  logic [2:0]       req0_bonus,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_src1,
    input  logic [WIDTH-1:0] req1_src2,
    input  logic [3:0]       req1_op,
    input  logic [2:0]       req1_bonus,
    // ALU side
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       alu_bonus,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_zcv,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_prio;
    logic             r_id;
    logic [WIDTH-1:0] r_alu_src1;
    logic [WIDTH-1:0] r_alu_src2;
    logic [3:0]       r_alu_ctrl;
    logic [2:0]       r_alu_bonus;
    logic [WIDTH-1:0] r_rsp_result;
    logic [2:0]       r_rsp_zcv;
    logic             r_rsp_err;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_illegal;
    logic             w_arith;

    assign alu_src1   = r_alu_src1;
    assign alu_src2   = r_alu_src2;
    assign alu_ctrl   = r_alu_ctrl;
    assign alu_bonus  = r_alu_bonus;
    assign rsp_id     = r_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zcv    = r_rsp_zcv;
    assign rsp_err    = r_rsp_err;

    // A lone requester always wins; a tie goes to the priority pointer.
    assign w_grant_id = (req0_valid && req1_valid) ? r_prio : req1_valid;
    assign w_accept   = req0_ready || req1_ready;

    // State register.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: accept -> EXEC -> RESP -> (consumer takes it) -> IDLE.
    // NOTE: the default assignment at the top keeps this combinational block
    // from inferring a latch on paths that do not change state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: ready only for the granted port in IDLE, response valid in RESP.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = (r_state == RESP);
        if (rst_n && (r_state == IDLE)) begin
            req0_ready = req0_valid && !w_grant_id;
            req1_ready = req1_valid &&  w_grant_id;
        end
    end

    // Operand registers feeding the ALU; loaded only on a request handshake.
    // NOTE: every register here is plain flops (no memory array), so all of
    // them get an explicit reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_src1  <= '0;
            r_alu_src2  <= '0;
            r_alu_ctrl  <= '0;
            r_alu_bonus <= '0;
            r_id        <= 1'b0;
        end else if (w_accept) begin
            r_id <= w_grant_id;
            if (w_grant_id) begin
                r_alu_src1  <= req1_src1;
                r_alu_src2  <= req1_src2;
                r_alu_ctrl  <= req1_op;
                r_alu_bonus <= req1_bonus;
            end else begin
                r_alu_src1  <= req0_src1;
                r_alu_src2  <= req0_src2;
                r_alu_ctrl  <= req0_op;
                r_alu_bonus <= req0_bonus;
            end
        end
    end

    // Decode whether the registered op is one the ALU defines.
    always_comb begin
        w_illegal = 1'b0;
        case (r_alu_ctrl)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd13: w_illegal = 1'b0;
            4'd7:    w_illegal = (r_alu_bonus == 3'd5) || (r_alu_bonus == 3'd7);
            default: w_illegal = 1'b1;
        endcase
    end

    // Carry and overflow only carry meaning for ADD and SUB.
    assign w_arith = (r_alu_ctrl == 4'd2) || (r_alu_ctrl == 4'd6);

    // Capture the ALU result and masked flags at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_result <= '0;
            r_rsp_zcv    <= '0;
            r_rsp_err    <= 1'b0;
        end else if (r_state == EXEC) begin
            if (w_illegal) begin
                r_rsp_result <= '0;
                r_rsp_zcv    <= 3'b000;
                r_rsp_err    <= 1'b1;
            end else begin
                r_rsp_result <= alu_result;
                r_rsp_zcv    <= {alu_zero, (w_arith ? {alu_cout, alu_overflow} : 2'b00)};
                r_rsp_err    <= 1'b0;
            end
        end
    end

    // Round-robin pointer: the other port wins the next tie once a response retires.
    always_ff @(posedge clk) begin
        if (!rst_n)                            r_prio <= 1'b0;
        else if ((r_state == RESP) && rsp_ready) r_prio <= ~r_id;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a stand-in ALU drives the ALU-side inputs,
// directed scenarios plus a randomized run are checked against a
// reference model of arbitration and response contents.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [3:0]   req0_op, req1_op;
    logic [2:0]   req0_bonus, req1_bonus;
    logic [W-1:0] alu_src1, alu_src2, alu_result;
    logic [3:0]   alu_ctrl;
    logic [2:0]   alu_bonus;
    logic         alu_zero, alu_cout, alu_overflow;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_zcv;

    int total = 0;
    int bad   = 0;
    bit m_prio = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req0_op(req0_op), .req0_bonus(req0_bonus),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .req1_op(req1_op), .req1_bonus(req1_bonus),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zcv(rsp_zcv), .rsp_err(rsp_err)
    );

    // Stand-in ALU. Logical ops report cout/overflow as 1 so masking is visible;
    // SUB reports borrow on cout; undefined codes return junk.
    logic [W:0] stub_sum, stub_sub;
    logic       stub_ovf_sub, stub_lt, stub_eq, stub_cmp;
    always_comb begin
        stub_sum     = {1'b0, alu_src1} + {1'b0, alu_src2};
        stub_sub     = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
        stub_ovf_sub = (alu_src1[W-1] != alu_src2[W-1]) && (stub_sub[W-1] != alu_src1[W-1]);
        stub_lt      = stub_sub[W-1] ^ stub_ovf_sub;
        stub_eq      = (alu_src1 == alu_src2);
        stub_cmp     = 1'b0;
        alu_result   = '0;
        alu_cout     = 1'b1;
        alu_overflow = 1'b1;
        case (alu_ctrl)
            4'd0:  alu_result = alu_src1 & alu_src2;
            4'd1:  alu_result = alu_src1 | alu_src2;
            4'd2: begin
                alu_result   = stub_sum[W-1:0];
                alu_cout     = stub_sum[W];
                alu_overflow = (alu_src1[W-1] == alu_src2[W-1]) && (stub_sum[W-1] != alu_src1[W-1]);
            end
            4'd6: begin
                alu_result   = stub_sub[W-1:0];
                alu_cout     = ~stub_sub[W];
                alu_overflow = stub_ovf_sub;
            end
            4'd7: begin
                case (alu_bonus)
                    3'd0: stub_cmp = stub_lt;
                    3'd1: stub_cmp = !stub_lt && !stub_eq;
                    3'd2: stub_cmp = stub_lt || stub_eq;
                    3'd3: stub_cmp = !stub_lt;
                    3'd4: stub_cmp = !stub_eq;
                    3'd6: stub_cmp = stub_eq;
                    default: stub_cmp = 1'b0;
                endcase
                alu_result = ((alu_bonus == 3'd5) || (alu_bonus == 3'd7)) ? 32'hDEAD_BEEF
                                                                          : {31'd0, stub_cmp};
            end
            4'd12: alu_result = ~(alu_src1 | alu_src2);
            4'd13: alu_result = ~(alu_src1 & alu_src2);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Reference response {err, zero, cout, ovf, result} from the op table.
    function automatic logic [35:0] ref_rsp(input logic [3:0] op, input logic [2:0] bo,
                                            input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [31:0] r = '0;
        bit c = 0, v = 0, legal = 1, t = 0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                r = a + b;
                c = (ua + ub) > 64'sd4294967295;
                v = ((sa + sb) > MAXI) || ((sa + sb) < MINI);
            end
            4'd6: begin
                r = a - b;
                c = ua < ub;
                v = ((sa - sb) > MAXI) || ((sa - sb) < MINI);
            end
            4'd7: begin
                case (bo)
                    3'd0: t = sa <  sb;
                    3'd1: t = sa >  sb;
                    3'd2: t = sa <= sb;
                    3'd3: t = sa >= sb;
                    3'd4: t = sa != sb;
                    3'd6: t = sa == sb;
                    default: legal = 0;
                endcase
                r = {31'd0, t};
            end
            4'd12: r = ~(a | b);
            4'd13: r = ~(a & b);
            default: legal = 0;
        endcase
        if (!legal) return {1'b1, 3'b000, 32'd0};
        return {1'b0, (r == 32'd0), c, v, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [3:0] op, input logic [2:0] bo,
                            input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_bonus = bo; req0_src1 = a; req0_src2 = b;
        end else begin
            req1_valid = v; req1_op = op; req1_bonus = bo; req1_src1 = a; req1_src2 = b;
        end
    endtask

    task automatic check_rsp(input string tag, input bit g, input logic [35:0] e);
        check({tag, "_valid"},  rsp_valid,  1);
        check({tag, "_id"},     rsp_id,     g);
        check({tag, "_result"}, rsp_result, e[31:0]);
        check({tag, "_zcv"},    rsp_zcv,    e[34:32]);
        check({tag, "_err"},    rsp_err,    e[35]);
    endtask

    // One full transaction from an IDLE cycle with the ports already driven;
    // the consumer stalls for 'stall' RESP cycles before accepting.
    task automatic do_txn(input string tag, input int stall);
        bit g;
        logic [3:0]  op;
        logic [2:0]  bo;
        logic [31:0] a, b;
        logic [35:0] e;
        #1;
        g = (req0_valid && req1_valid) ? m_prio : req1_valid;
        check({tag, "_rdy0"}, req0_ready, (req0_valid && g == 0));
        check({tag, "_rdy1"}, req1_ready, (req1_valid && g == 1));
        if (g) begin op = req1_op; bo = req1_bonus; a = req1_src1; b = req1_src2; end
        else   begin op = req0_op; bo = req0_bonus; a = req0_src1; b = req0_src2; end
        e = ref_rsp(op, bo, a, b);
        rsp_ready = (stall == 0);
        step();
        check({tag, "_exec_valid"}, rsp_valid, 0);
        check({tag, "_exec_rdy"},   {req0_ready, req1_ready}, 2'b00);
        check({tag, "_alu_ops"},    {alu_src1, alu_src2}, {a, b});
        check({tag, "_alu_ctl"},    {alu_ctrl, alu_bonus}, {op, bo});
        step();
        for (int k = 0; k < stall; k++) begin
            check_rsp({tag, "_hold"}, g, e);
            check({tag, "_hold_rdy"}, {req0_ready, req1_ready}, 2'b00);
            step();
        end
        rsp_ready = 1'b1;
        check_rsp(tag, g, e);
        step();
        check({tag, "_done_valid"}, rsp_valid, 0);
        m_prio = ~g;
    endtask

    logic [3:0] op_pool [12] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd7, 4'd7,
                                 4'd12, 4'd13, 4'd2, 4'd5, 4'd14};

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        set_port(0, 1, 4'd2, 3'd0, 32'h1234_5678, 32'h1);
        set_port(1, 1, 4'd1, 3'd0, 32'h8765_4321, 32'h2);
        #1;
        check("rst_rdy_pre", {req0_ready, req1_ready}, 2'b00);
        step();
        step();
        check("rst_rdy",   {req0_ready, req1_ready}, 2'b00);
        check("rst_valid", rsp_valid, 0);
        check("rst_alu",   {alu_src1, alu_src2, alu_ctrl, alu_bonus}, '0);
        check("rst_rsp",   {rsp_result, rsp_zcv, rsp_id, rsp_err}, '0);
        set_port(0, 0, 4'd0, 3'd0, 32'h0, 32'h0);
        set_port(1, 0, 4'd0, 3'd0, 32'h0, 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_novalid", {rsp_valid, req0_ready, req1_ready}, 3'b000);

        // single add with signed overflow
        set_port(0, 1, 4'd2, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        do_txn("add", 0);
        set_port(0, 0, 4'd0, 3'd0, 32'h0, 32'h0);
        step();
        check("idle_hold_alu", {alu_src1, alu_src2, alu_ctrl}, {32'h7FFF_FFFF, 32'h1, 4'd2});

        // bonus compare and flag masking from port 1
        set_port(1, 1, 4'd7, 3'd6, 32'd3, 32'd3);
        do_txn("seq", 0);
        set_port(1, 1, 4'd12, 3'd0, 32'd0, 32'd0);
        do_txn("nor", 0);
        set_port(1, 0, 4'd0, 3'd0, 32'h0, 32'h0);

        // tie fairness with both ports continuously valid
        set_port(0, 1, 4'd6, 3'd0, 32'd5, 32'd5);
        set_port(1, 1, 4'd0, 3'd0, 32'h0000_F0F0, 32'h0000_0F0F);
        for (int i = 0; i < 4; i++) do_txn("tie", 0);

        // backpressure, then the waiting port is accepted straight away
        set_port(0, 1, 4'd2, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        do_txn("bp", 5);
        do_txn("bp_next", 0);

        // illegal op codes
        set_port(0, 1, 4'd5, 3'd0, 32'h1, 32'h2);
        set_port(1, 1, 4'd7, 3'd5, 32'h3, 32'h4);
        do_txn("illegal_a", 0);
        do_txn("illegal_b", 1);
        set_port(0, 0, 4'd0, 3'd0, 32'h0, 32'h0);
        set_port(1, 0, 4'd0, 3'd0, 32'h0, 32'h0);
        step();

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            int vv;
            logic [31:0] a0, b0, a1, b1;
            vv = $urandom_range(1, 3);
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            set_port(0, vv[0], op_pool[$urandom_range(0, 11)], 3'($urandom_range(0, 7)), a0, b0);
            set_port(1, vv[1], op_pool[$urandom_range(0, 11)], 3'($urandom_range(0, 7)), a1, b1);
            do_txn("rand", $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) begin
                set_port(0, 0, 4'd0, 3'd0, 32'h0, 32'h0);
                set_port(1, 0, 4'd0, 3'd0, 32'h0, 32'h0);
                step();
                check("rand_idle", {rsp_valid, req0_ready, req1_ready}, 3'b000);
            end
        end

        // reset while a response is pending; pointer must return to port 0
        set_port(1, 0, 4'd0, 3'd0, 32'h0, 32'h0);
        set_port(0, 1, 4'd1, 3'd0, 32'h10, 32'h01);
        do_txn("pre_rst", 0);
        #1;
        check("rst_acc_rdy0", req0_ready, 1);
        rsp_ready = 1'b0;
        step();
        step();
        check("rst_in_resp_valid", rsp_valid, 1);
        rst_n = 1'b0;
        set_port(1, 1, 4'd2, 3'd0, 32'h5, 32'h6);
        step();
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_rdy",   {req0_ready, req1_ready}, 2'b00);
        check("rst_mid_rsp",   {rsp_result, rsp_zcv, rsp_err}, '0);
        rst_n = 1'b1;
        m_prio = 1'b0;
        do_txn("post_rst_tie", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
